// File: rtl/agc_shift.sv
// agc_shift: receive-side AGC. Applies a left-shift gain (adapted once per
//   window from the peak magnitude) and saturates to +/-SAT_LIMIT.
// Latency: 1 cycle from accepted sample to data_out/out_valid.
// Backpressure: in_ready = !out_valid || out_ready (single output register,
//   no skid), forced low during the one-cycle UPDATE after each window.
// Ports:
//   clk_in, rst_in (sync, active-high)
//   data_in/in_valid/in_ready     : signed 32-bit input stream
//   data_out/out_valid/out_ready  : signed 32-bit gained, saturated stream
//   shift_out                     : current gain shift
//   win_done                      : one-cycle pulse when a window closes
//   clip_count (AGC_CLIP_COUNT_EN): saturated samples in the last window
// Optional feature macro: AGC_CLIP_COUNT_EN
module agc_shift #(
  parameter int WIN_LOG2    = 10,
  parameter int MAX_SHIFT   = 15,
  parameter int SAT_LIMIT   = 1000000000,
  parameter int LOW_THRESH  = 268435456,
  parameter int HIGH_THRESH = 1073741824
) (
  input  logic                           clk_in,
  input  logic                           rst_in,
  input  logic [31:0]                    data_in,
  input  logic                           in_valid,
  output logic                           in_ready,
  output logic [31:0]                    data_out,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [$clog2(MAX_SHIFT+1)-1:0] shift_out,
  output logic                           win_done
`ifdef AGC_CLIP_COUNT_EN
  ,
  output logic [15:0]                    clip_count
`endif
);

  localparam int SW = $clog2(MAX_SHIFT + 1);

  localparam logic [0:0] ST_TRACK  = 1'b0;
  localparam logic [0:0] ST_UPDATE = 1'b1;

  localparam logic signed [47:0] SAT_P   = 48'(SAT_LIMIT);
  localparam logic signed [47:0] SAT_N   = -SAT_P;
  localparam logic signed [47:0] MAG_MAX = 48'sh0000_7FFF_FFFF;

  logic [0:0]          state_q, state_d;
  logic [WIN_LOG2-1:0] cnt_q, cnt_d;
  logic [31:0]         peak_q, peak_d;
  logic [SW-1:0]       shift_q, shift_d;
  logic [31:0]         dout_q, dout_d;
  logic                ovld_q, ovld_d;
  logic                wd_q, wd_d;

  logic                accept, last;
  logic signed [47:0]  s_ext, s_shl, s_abs;
  logic                sat_hi, sat_lo;
  logic [31:0]         mag, peak_new;

  assign in_ready = (state_q == ST_TRACK) && (!ovld_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign last     = (cnt_q == {WIN_LOG2{1'b1}});

  // 48 bits hold a 32-bit sample shifted by up to 15 without overflow.
  assign s_ext  = $signed({{16{data_in[31]}}, data_in});
  assign s_shl  = s_ext <<< shift_q;
  assign sat_hi = (s_shl > SAT_P);
  assign sat_lo = (s_shl < SAT_N);
  assign s_abs  = s_shl[47] ? -s_shl : s_shl;
  // -2^31 at shift 0 has magnitude 2^31, which is pinned to 2^31-1.
  assign mag      = (s_abs > MAG_MAX) ? 32'h7FFF_FFFF : s_abs[31:0];
  assign peak_new = (mag > peak_q) ? mag : peak_q;

  always_comb begin
    state_d = ST_TRACK;
    cnt_d   = cnt_q;
    peak_d  = peak_q;
    shift_d = shift_q;
    dout_d  = dout_q;
    ovld_d  = ovld_q;
    wd_d    = 1'b0;

    if (accept) begin
      ovld_d = 1'b1;
      if (sat_hi)      dout_d = SAT_P[31:0];
      else if (sat_lo) dout_d = SAT_N[31:0];
      else             dout_d = s_shl[31:0];

      cnt_d  = cnt_q + 1'b1;
      peak_d = peak_new;
      if (last) begin
        // Decision uses the peak including the window-closing sample;
        // that sample itself was gained with the old shift above.
        if ((peak_new > 32'(HIGH_THRESH)) && (shift_q != '0))
          shift_d = shift_q - 1'b1;
        else if ((peak_new < 32'(LOW_THRESH)) && (shift_q < SW'(MAX_SHIFT)))
          shift_d = shift_q + 1'b1;
        peak_d  = '0;
        wd_d    = 1'b1;
        state_d = ST_UPDATE;
      end
    end else if (out_ready) begin
      ovld_d = 1'b0;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= ST_TRACK;
      cnt_q   <= '0;
      peak_q  <= '0;
      shift_q <= '0;
      dout_q  <= '0;
      ovld_q  <= 1'b0;
      wd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      peak_q  <= peak_d;
      shift_q <= shift_d;
      dout_q  <= dout_d;
      ovld_q  <= ovld_d;
      wd_q    <= wd_d;
    end
  end

  assign data_out  = dout_q;
  assign out_valid = ovld_q;
  assign shift_out = shift_q;
  assign win_done  = wd_q;

`ifdef AGC_CLIP_COUNT_EN
  logic [15:0] clip_live_q, clip_live_d;
  logic [15:0] clip_cnt_q, clip_cnt_d;
  logic [15:0] clip_sum;

  // Live count including the current sample, saturating at 65535.
  assign clip_sum = (accept && (sat_hi || sat_lo) && (clip_live_q != 16'hFFFF))
                  ? clip_live_q + 16'd1 : clip_live_q;

  always_comb begin
    clip_live_d = clip_live_q;
    clip_cnt_d  = clip_cnt_q;
    if (accept) begin
      if (last) begin
        clip_cnt_d  = clip_sum;
        clip_live_d = '0;
      end else begin
        clip_live_d = clip_sum;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      clip_live_q <= '0;
      clip_cnt_q  <= '0;
    end else begin
      clip_live_q <= clip_live_d;
      clip_cnt_q  <= clip_cnt_d;
    end
  end

  assign clip_count = clip_cnt_q;
`endif

endmodule

// File: tb/tb_agc_shift.sv
// Bench for agc_shift with WIN_LOG2=2 (4-sample windows).
// A negedge monitor keeps a reference model of gain/window behaviour and a
// scoreboard of expected outputs; scenario tasks drive stimulus and check.
module tb_agc_shift;
  localparam int WL   = 2;
  localparam int MAXS = 15;
  localparam longint SAT  = 1000000000;
  localparam longint LOW  = 268435456;
  localparam longint HIGH = 1073741824;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic [31:0] data_in = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] data_out;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [3:0]  shift_out;
  logic        win_done;

  always #5 clk_in = ~clk_in;

  agc_shift #(
    .WIN_LOG2(WL), .MAX_SHIFT(MAXS), .SAT_LIMIT(1000000000),
    .LOW_THRESH(268435456), .HIGH_THRESH(1073741824)
  ) dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .data_in(data_in), .in_valid(in_valid), .in_ready(in_ready),
    .data_out(data_out), .out_valid(out_valid), .out_ready(out_ready),
    .shift_out(shift_out), .win_done(win_done)
  );

  int checks = 0;
  int errors = 0;

  logic [31:0] sb_q[$];
  logic [31:0] stim_q[$];
  int          m_shift = 0;
  int          m_cnt = 0;
  longint      m_peak = 0;
  bit          m_upd = 1'b0;
  int          acc_count = 0;
  int          wd_count = 0;
  logic [31:0] last_out = '0;

  // Reference model and scoreboard; acceptances and consumptions are
  // observed at the negedge preceding the edge on which they happen.
  always @(negedge clk_in) begin
    longint      s;
    longint      mag;
    logic [31:0] e;
    bit          exp_rdy;
    if (rst_in) begin
      sb_q.delete();
      m_shift = 0;
      m_cnt   = 0;
      m_peak  = 0;
      m_upd   = 1'b0;
    end else begin
      checks++;
      if (win_done !== m_upd) begin
        errors++;
        $display("FAIL win_done: got %b expected %b at %0t", win_done, m_upd, $time);
      end
      checks++;
      if (shift_out !== 4'(m_shift)) begin
        errors++;
        $display("FAIL shift_out: got %0d expected %0d at %0t", shift_out, m_shift, $time);
      end
      exp_rdy = !m_upd && (!out_valid || out_ready);
      checks++;
      if (in_ready !== exp_rdy) begin
        errors++;
        $display("FAIL in_ready: got %b expected %b at %0t", in_ready, exp_rdy, $time);
      end
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        last_out = data_out;
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_output: got %0d expected none at %0t", $signed(data_out), $time);
        end else begin
          e = sb_q.pop_front();
          if (data_out !== e) begin
            errors++;
            $display("FAIL data_out: got %0d expected %0d at %0t", $signed(data_out), $signed(e), $time);
          end
        end
      end
      if (win_done === 1'b1) wd_count++;
      m_upd = 1'b0;
      if (in_valid === 1'b1 && in_ready === 1'b1) begin
        acc_count++;
        s = longint'($signed(data_in)) * (longint'(1) << m_shift);
        if (s > SAT)       e = 32'(SAT);
        else if (s < -SAT) e = 32'(-SAT);
        else               e = s[31:0];
        sb_q.push_back(e);
        mag = (s < 0) ? -s : s;
        if (mag > 64'd2147483647) mag = 2147483647;
        if (mag > m_peak) m_peak = mag;
        if (m_cnt == (1 << WL) - 1) begin
          if (m_peak > HIGH && m_shift > 0)         m_shift = m_shift - 1;
          else if (m_peak < LOW && m_shift < MAXS)  m_shift = m_shift + 1;
          m_cnt  = 0;
          m_peak = 0;
          m_upd  = 1'b1;
        end else begin
          m_cnt = m_cnt + 1;
        end
      end
    end
  end

  task automatic do_reset(input int n);
    rst_in   = 1'b1;
    in_valid = 1'b0;
    repeat (n) @(posedge clk_in);
    #1;
    rst_in = 1'b0;
  endtask

  task automatic push_n(input int n, input logic [31:0] v);
    for (int i = 0; i < n; i++) stim_q.push_back(v);
  endtask

  // Present stim_q in order, holding each word until accepted.
  task automatic run_stream(input int budget);
    int cyc = 0;
    bit acc;
    while (stim_q.size() > 0 && cyc < budget) begin
      in_valid = 1'b1;
      data_in  = stim_q[0];
      @(negedge clk_in);
      acc = (in_ready === 1'b1);
      @(posedge clk_in);
      #1;
      if (acc) void'(stim_q.pop_front());
      cyc++;
    end
    in_valid = 1'b0;
    if (stim_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL stream_timeout: got %0d words left expected 0", stim_q.size());
      stim_q.delete();
    end
  endtask

  task automatic wait_drain(input int budget);
    int cyc = 0;
    while ((sb_q.size() > 0 || out_valid !== 1'b0) && cyc < budget) begin
      @(posedge clk_in);
      #1;
      cyc++;
    end
    checks++;
    if (sb_q.size() > 0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb_q.size());
    end
  endtask

  task automatic send(input int budget);
    run_stream(budget);
    wait_drain(budget);
  endtask

  task automatic test_reset;
    out_ready = 1'b1;
    do_reset(2);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b expected 0", out_valid); end
    checks++;
    if (shift_out !== 4'd0) begin errors++; $display("FAIL rst_shift: got %0d expected 0", shift_out); end
    checks++;
    if (data_out !== 32'd0) begin errors++; $display("FAIL rst_data_out: got %0d expected 0", data_out); end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %b expected 1", in_ready); end
    checks++;
    if (win_done !== 1'b0) begin errors++; $display("FAIL rst_win_done: got %b expected 0", win_done); end
  endtask

  task automatic test_gain_up;
    int w0;
    do_reset(1);
    w0 = wd_count;
    push_n(4, 32'd1000);
    send(50);
    checks++;
    if (wd_count - w0 !== 1) begin errors++; $display("FAIL up_win_done_count: got %0d expected 1", wd_count - w0); end
    checks++;
    if (shift_out !== 4'd1) begin errors++; $display("FAIL up_shift: got %0d expected 1", shift_out); end
    push_n(1, 32'd1000);
    send(50);
    checks++;
    if (last_out !== 32'd2000) begin errors++; $display("FAIL up_data: got %0d expected 2000", $signed(last_out)); end
  endtask

  task automatic test_gain_down;
    do_reset(1);
    push_n(12, 32'd0);
    send(100);
    checks++;
    if (shift_out !== 4'd3) begin errors++; $display("FAIL down_preload: got %0d expected 3", shift_out); end
    push_n(4, 32'd200000000);
    send(50);
    checks++;
    if (last_out !== 32'd1000000000) begin errors++; $display("FAIL down_clamp: got %0d expected 1000000000", $signed(last_out)); end
    checks++;
    if (shift_out !== 4'd2) begin errors++; $display("FAIL down_shift: got %0d expected 2", shift_out); end
  endtask

  task automatic test_saturation;
    logic [31:0] vin[3];
    logic [31:0] vexp[3];
    vin  = '{32'd2000000000, 32'h8000_0000, 32'hFFFF_FFFB};
    vexp = '{32'd1000000000, 32'hC465_3600, 32'hFFFF_FFFB};
    do_reset(1);
    for (int i = 0; i < 3; i++) begin
      push_n(1, vin[i]);
      send(50);
      checks++;
      if (last_out !== vexp[i]) begin
        errors++;
        $display("FAIL sat_%0d: got %0d expected %0d", i, $signed(last_out), $signed(vexp[i]));
      end
    end
    push_n(1, 32'd7);
    send(50);
    checks++;
    if (shift_out !== 4'd0) begin errors++; $display("FAIL sat_shift_floor: got %0d expected 0", shift_out); end
  endtask

  task automatic test_max_shift;
    do_reset(1);
    push_n(64, 32'd0);
    send(400);
    checks++;
    if (shift_out !== 4'd15) begin errors++; $display("FAIL max_shift: got %0d expected 15", shift_out); end
    push_n(1, 32'd1);
    send(50);
    checks++;
    if (last_out !== 32'd32768) begin errors++; $display("FAIL max_shift_data: got %0d expected 32768", $signed(last_out)); end
  endtask

  task automatic test_backpressure;
    int a0;
    do_reset(1);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    data_in   = 32'd111;
    a0 = acc_count;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_in);
      if (i > 0) begin
        checks++;
        if (data_out !== 32'd111) begin errors++; $display("FAIL bp_stable_%0d: got %0d expected 111", i, data_out); end
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready_%0d: got %b expected 0", i, in_ready); end
      end
      @(posedge clk_in);
      #1;
      if (acc_count != a0) data_in = 32'd222;
    end
    checks++;
    if (acc_count - a0 !== 1) begin errors++; $display("FAIL bp_accepted: got %0d expected 1", acc_count - a0); end
    out_ready = 1'b1;
    stim_q.push_back(32'd222);
    stim_q.push_back(32'd333);
    send(50);
    checks++;
    if (acc_count - a0 !== 3) begin errors++; $display("FAIL bp_total: got %0d expected 3", acc_count - a0); end
    checks++;
    if (last_out !== 32'd333) begin errors++; $display("FAIL bp_last: got %0d expected 333", last_out); end
  endtask

  task automatic test_mid_reset;
    int w0;
    do_reset(1);
    push_n(4, 32'd0);
    send(50);
    checks++;
    if (shift_out !== 4'd1) begin errors++; $display("FAIL mid_preload: got %0d expected 1", shift_out); end
    push_n(2, 32'd1000);
    send(50);
    do_reset(1);
    checks++;
    if (shift_out !== 4'd0) begin errors++; $display("FAIL mid_rst_shift: got %0d expected 0", shift_out); end
    w0 = wd_count;
    push_n(2, 32'd1000);
    send(50);
    checks++;
    if (wd_count !== w0) begin errors++; $display("FAIL mid_early_win: got %0d expected %0d", wd_count, w0); end
    push_n(2, 32'd1000);
    send(50);
    checks++;
    if (wd_count !== w0 + 1) begin errors++; $display("FAIL mid_win: got %0d expected %0d", wd_count, w0 + 1); end
    checks++;
    if (shift_out !== 4'd1) begin errors++; $display("FAIL mid_shift: got %0d expected 1", shift_out); end
  endtask

  initial begin
    test_reset();
    test_gain_up();
    test_gain_down();
    test_saturation();
    test_max_shift();
    test_backpressure();
    test_mid_reset();
    repeat (3) @(posedge clk_in);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/agc_shift.md
Name: agc_shift

Overview:
- Receive-side automatic gain stage; the counterpart to the transmit-path output limiter.
- Takes 32-bit signed baseband samples and applies a left-shift gain adapted once per window from the measured peak magnitude.
- Saturates the result to ±SAT_LIMIT.
- Streams with valid/ready on both sides; sits between the demodulator front end and downstream DSP.

Parameters:
- WIN_LOG2, 10, window length = 2^WIN_LOG2 accepted samples
- MAX_SHIFT, 15, maximum gain shift (range 0..MAX_SHIFT)
- SAT_LIMIT, 1000000000, positive output clamp; negative clamp is -SAT_LIMIT
- LOW_THRESH, 268435456, window peak below this increases shift
- HIGH_THRESH, 1073741824, window peak above this decreases shift

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  synchronous active-high reset
- data_in  input  32  signed input sample
- in_valid  input  1  data_in valid
- in_ready  output  1  block can accept a sample this cycle
- data_out  output  32  signed gained, saturated sample
- out_valid  output  1  data_out valid
- out_ready  input  1  downstream accepts data_out
- shift_out  output  4  current gain shift (width $clog2(MAX_SHIFT+1))
- win_done  output  1  one-cycle pulse when a window closes and shift updates

Behaviour:
- Interface and reset:
  - Single clock clk_in; rst_in is synchronous, active-high.
  - Reset values: data_out=0, out_valid=0, shift_out=0, win_done=0, window counter=0, peak=0.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational; single output register, no skid).
  - A sample is accepted when in_valid && in_ready.
  - data_out and out_valid update on the clock edge after acceptance: latency 1 cycle.
  - out_valid clears only on out_ready without a new acceptance.
  - data_out is held stable while out_valid && !out_ready.
- Datapath per accepted sample:
  - s = sign-extend(data_in) to 48 bits, then arithmetic left-shift by the current shift.
  - data_out = SAT_LIMIT if s > SAT_LIMIT; -SAT_LIMIT if s < -SAT_LIMIT; otherwise s[31:0].
  - mag = |s|, clamped to 2^31-1.
  - peak = max(peak, mag).
- Window FSM, two states:
  - TRACK: counts accepted samples.
  - On the accepted sample with count == 2^WIN_LOG2-1, the FSM evaluates, in the same cycle, the peak including that sample.
  - Decision:
    - If peak > HIGH_THRESH and shift > 0: shift-1.
    - Else if peak < LOW_THRESH and shift < MAX_SHIFT: shift+1.
    - Else: hold.
  - On that edge: count wraps to 0, peak resets to 0, win_done pulses for one cycle, and the FSM enters UPDATE.
  - UPDATE: lasts one cycle; in_ready is forced low. Returns to TRACK.
- Shift timing: the window-closing sample uses the old shift. The new shift applies from the first sample accepted after UPDATE.
- Boundaries:
  - data_in = -2^31 at shift 0 gives mag = 2^31-1 and data_out = -SAT_LIMIT.
  - Shift never wraps below 0 or above MAX_SHIFT.
  - Cycles with no acceptance change neither count nor peak.
  - rst_in mid-window discards the partial window and sets shift to 0; an in-flight output is dropped (out_valid=0).

Optional Feature:
- Macro AGC_CLIP_COUNT_EN.
- Defined:
  - Adds output port clip_count (16 bits, reset 0), which counts accepted samples that saturated in the current window. It is sampled into a register at window close, then the live counter clears.
  - The counter saturates at 65535.
  - win_done also qualifies clip_count as fresh.
- Undefined: the port and logic are absent; all other behaviour is identical.

Test Plan:
- Reset: assert rst_in 2 cycles -> out_valid=0, shift_out=0, data_out=0, in_ready=1 after UPDATE-free idle.
- Gain increase (WIN_LOG2=2): 4 samples of 1000 with out_ready=1 -> win_done pulse, shift_out=1; next sample 1000 -> data_out=2000.
- Gain decrease (WIN_LOG2=2, preload shift 3 via 3 quiet windows): window holding 200000000 -> shifted 1.6e9 clamps data_out=1000000000; window close -> shift_out=2.
- Saturation at shift 0: 2000000000 -> 1000000000; -2147483648 -> -1000000000; -5 -> -5.
- Backpressure: out_ready=0 for 5 cycles with in_valid=1 -> in_ready=0, data_out stable, exactly one sample accepted. Release -> samples emerge in order, none lost or duplicated.
- Mid-window reset: 2 of 4 samples accepted, pulse rst_in -> shift_out=0. The next 4 samples form a full window: win_done fires after the 4th sample, not the 2nd.
